uart_port: RTL and testbench
============================

Name: uart_port

Overview:
- On-FPGA UART that answers the CPU's serial-port strobes (rdn, wrn) and status lines (data_ready, tsre, tbre), which the RAM/peripheral controller uses for address 0xBF00/0xBF01.
- Serialises CPU writes onto txd. Deserialises rxd into a one-byte receive buffer.
- Frame format: 8N1, LSB first. Includes one holding register and one shift register on the transmit side.

Parameters:
- CLKS_PER_BIT, 434, clk_50MHz cycles per bit (50 MHz / 115200 baud). Must be ≥ 4.
- CNT_W, 16, width of the bit-timing counters.

Ports:
- clk_50MHz  input  1  system clock; all logic on posedge
- rst  input  1  synchronous reset, active-high
- data_i  input  16  write data; bits [7:0] are used
- data_o  output  16  read data: {8'h00, rbr} while rdn=0, else 16'h0000; registered
- rdn  input  1  active-low read strobe, synchronous to clk_50MHz
- wrn  input  1  active-low write strobe, synchronous to clk_50MHz
- data_ready  output  1  receive buffer holds an unread byte
- tbre  output  1  transmit holding register empty
- tsre  output  1  transmit shift register empty (line idle)
- overrun  output  1  sticky: a received byte was overwritten before being read
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous

Behaviour:
- Reset values: txd=1, tbre=1, tsre=1, data_ready=0, overrun=0, data_o=0. Both FSMs go to IDLE and all counters clear. Reset mid-frame aborts the frame; txd returns to 1 on the next cycle.
- Strobe edges:
  - wrn_q and rdn_q hold the previous-cycle values; both reset to 1.
  - Write event: wrn=0 && wrn_q=1.
  - Read-end event: rdn=1 && rdn_q=0.
- Write:
  - On a write event with tbre=1: THR <= data_i[7:0]; tbre=0 on the next cycle.
  - On a write event with tbre=0: the write is dropped and no state changes.
- TX FSM: IDLE, START, DATA, STOP.
  - IDLE with tbre=0: TSR <= THR, tbre=1, tsre=0, enter START, txd=0. All of this is visible on the cycle after tbre fell.
  - START lasts CLKS_PER_BIT cycles.
  - DATA: 8 bits of CLKS_PER_BIT cycles each; txd=TSR[0], TSR shifts right once per bit.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
  - At the end of STOP with tbre=0: reload immediately with no idle gap; tsre stays 0 and the next START begins on the following cycle.
  - At the end of STOP with tbre=1: go to IDLE, tsre=1.
  - A single write sampled at cycle N gives: tbre=0 at N+1; txd=0, tbre=1, tsre=0 at N+2; tsre=1 at N+2+10*CLKS_PER_BIT.
- RX:
  - rxd passes through a 2-flop synchroniser (reset value 1); rxs is its output.
  - RX FSM: IDLE, START, DATA, STOP.
  - IDLE: rxs=0 moves to START with the counter cleared.
  - START: at CLKS_PER_BIT/2 (integer division), if rxs=1 it was a glitch, return to IDLE; otherwise go to DATA.
  - DATA: sample rxs every CLKS_PER_BIT into shift[7] and shift right; 8 samples in total.
  - STOP: sample after CLKS_PER_BIT.
    - rxs=1: rbr <= shift, data_ready=1 on the next cycle, go to IDLE.
    - rxs=0 (framing error): discard the byte, leave data_ready and rbr unchanged, return to IDLE. A new start is only recognised after rxs returns to 1.
- Read:
  - data_o = {8'h00, rbr} registered one cycle after rdn is sampled 0.
  - A read-end event clears data_ready and overrun.
  - A byte that completes while data_ready=1 overwrites rbr and sets overrun=1.
  - If a byte completes in the same cycle as a read-end event: data_ready stays 1 with the new byte, and overrun is cleared, not set.
- Independence and widths:
  - TX and RX operate fully independently. Simultaneous wrn and rdn activity is legal.
  - Counters are CNT_W bits, reset to 0 at each bit boundary, and never wrap within a bit.

Test Plan (CLKS_PER_BIT=8):
- Reset, then idle 20 cycles -> txd=1, tbre=1, tsre=1, data_ready=0, data_o=0.
- Write 16'h00A5 with a 1-cycle wrn pulse at N -> tbre=0 at N+1; tbre=1, tsre=0 at N+2; txd bits 0,1,0,1,0,0,1,0,1,1 at 8-cycle intervals; tsre=1 at N+82.
- Two writes 0x55 then 0x0F, the second issued while tsre=0 -> frames are contiguous with no idle bit; a third write while tbre=0 is dropped and never appears on txd.
- Drive rxd with 0x3C at 8 cycles/bit -> data_ready rises after the stop sample; pulse rdn low -> data_o=16'h003C; data_ready=0 after rdn rises.
- Send 0x11 then 0x22 without reading -> overrun=1 and rbr=0x22; a subsequent read clears both flags. A 3-cycle low glitch on rxd gives no reception. A frame with stop bit 0 leaves data_ready=0.
- Assert rst mid TX frame and mid RX frame -> all outputs return to reset values on the next cycle; a subsequent clean frame is received correctly.

Source files
------------

// File: rtl/uart_port.sv
// 8N1 UART behind the CPU serial-port strobes: one-deep transmit holding register
// plus shift register, single-byte receive buffer with sticky overrun.
module uart_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  input  logic        rdn,
  input  logic        wrn,
  output logic        data_ready,
  output logic        tbre,
  output logic        tsre,
  output logic        overrun,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic wrn_q, rdn_q;
  logic wr_evt, rd_end;

  state_t           tx_st;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       thr, tsr;

  state_t           rx_st;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh, rbr;
  logic             rx_meta, rxs;
  logic             rx_hold;
  logic             rx_done;

  logic unused_hi;
  assign unused_hi = ^data_i[15:8];

  assign wr_evt  = !wrn && wrn_q;
  assign rd_end  = rdn && !rdn_q;
  assign rx_done = (rx_st == S_STOP) && (rx_cnt == BIT_END) && rxs;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      wrn_q <= 1'b1;
      rdn_q <= 1'b1;
    end else begin
      wrn_q <= wrn;
      rdn_q <= rdn;
    end
  end

  // Transmit side; writes only land in THR while it is empty.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      thr    <= '0;
      tsr    <= '0;
      tbre   <= 1'b1;
      tsre   <= 1'b1;
      txd    <= 1'b1;
    end else begin
      if (wr_evt && tbre) begin
        thr  <= data_i[7:0];
        tbre <= 1'b0;
      end
      case (tx_st)
        S_IDLE: begin
          if (!tbre) begin
            tsr    <= thr;
            tbre   <= 1'b1;
            tsre   <= 1'b0;
            txd    <= 1'b0;
            tx_cnt <= '0;
            tx_st  <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            txd    <= tsr[0];
            tsr    <= {1'b0, tsr[7:1]};
            tx_st  <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              txd   <= 1'b1;
              tx_st <= S_STOP;
            end else begin
              txd    <= tsr[0];
              tsr    <= {1'b0, tsr[7:1]};
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            // A pending byte goes straight into the next start bit, no idle gap.
            if (!tbre) begin
              tsr   <= thr;
              tbre  <= 1'b1;
              txd   <= 1'b0;
              tx_st <= S_START;
            end else begin
              tsre  <= 1'b1;
              tx_st <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  // Receive side; start bit is re-checked half a bit after the falling edge.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rx_st   <= S_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_hold <= 1'b0;
      rbr     <= '0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      case (rx_st)
        S_IDLE: begin
          // After a framing error the line must go high before a new start counts.
          if (rx_hold) begin
            if (rxs) rx_hold <= 1'b0;
          end else if (!rxs) begin
            rx_cnt <= '0;
            rx_st  <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rxs ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rxs, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_st <= S_STOP;
            else                rx_bit <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_st  <= S_IDLE;
            if (rxs) rbr     <= rx_sh;
            else     rx_hold <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // A byte landing on the same cycle as a read-end counts as fresh, not overrun.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      data_ready <= 1'b0;
      overrun    <= 1'b0;
      data_o     <= '0;
    end else begin
      if (rx_done) begin
        data_ready <= 1'b1;
        overrun    <= !rd_end && (data_ready || overrun);
      end else if (rd_end) begin
        data_ready <= 1'b0;
        overrun    <= 1'b0;
      end
      data_o <= !rdn ? {8'h00, rbr} : 16'h0000;
    end
  end

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port at 8 clocks per bit: vector table for the
// transmit path, hand-written sequences for receive, overrun and reset corners.
module tb_uart_port;
  localparam int CPB = 8;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_i = '0;
  logic [15:0] data_o;
  logic        rdn = 1'b1, wrn = 1'b1, rxd = 1'b1;
  logic        data_ready, tbre, tsre, overrun, txd;

  int n_vec = 0;
  int n_bad = 0;

  uart_port #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .data_i(data_i), .data_o(data_o),
    .rdn(rdn), .wrn(wrn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
    .overrun(overrun), .txd(txd), .rxd(rxd)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  typedef struct {
    string       nm;
    int          cyc;
    logic        wrn;
    logic [15:0] din;
    logic [5:0]  m;      // {dout, ov, dr, tsre, tbre, txd}
    logic        txd, tbre, tsre, dr, ov;
    logic [15:0] dout;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string nm, input int cyc, input logic w,
                              input logic [15:0] din, input logic [5:0] m,
                              input logic e_txd, input logic e_tbre, input logic e_tsre,
                              input logic e_dr, input logic e_ov, input logic [15:0] e_dout);
    vec_t v;
    v.nm = nm; v.cyc = cyc; v.wrn = w; v.din = din; v.m = m;
    v.txd = e_txd; v.tbre = e_tbre; v.tsre = e_tsre; v.dr = e_dr; v.ov = e_ov; v.dout = e_dout;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) step();
    end
    rxd = stop;
    repeat (CPB) step();
    rxd = 1'b1;
    repeat (4) step();
  endtask

  task automatic do_read(input string nm, input logic [15:0] exp);
    rdn = 1'b0;
    step();
    chk({nm, ".data_o"}, data_o, exp);
    rdn = 1'b1;
    step();
    chk({nm, ".dr_clr"}, {15'd0, data_ready}, 16'd0);
    chk({nm, ".ov_clr"}, {15'd0, overrun}, 16'd0);
    chk({nm, ".data_o_idle"}, data_o, 16'h0000);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] a5, f0;
    a5 = 8'hA5;
    f0 = 8'h0F;

    // Reset / idle, single frame 0xA5, then back-to-back 0x55 + 0x0F with a dropped 0xFF.
    vt.push_back(mk("idle", 20, 1, 0, 6'h3F, 1, 1, 1, 0, 0, 16'h0000));
    vt.push_back(mk("a5_wr", 1, 0, 16'h00A5, 6'h07, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk("a5_ld", 1, 1, 0, 6'h07, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      vt.push_back(mk($sformatf("a5_bit%0d", k), CPB, 1, 0, 6'h05, a5[k], 0, 0, 0, 0, 0));
    vt.push_back(mk("a5_stop", CPB, 1, 0, 6'h05, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("a5_pre", CPB - 1, 1, 0, 6'h04, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("a5_done", 1, 1, 0, 6'h07, 1, 1, 1, 0, 0, 0));
    vt.push_back(mk("b2b_wr1", 1, 0, 16'h0055, 6'h02, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("b2b_ld1", 1, 1, 0, 6'h07, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk("b2b_gap1", 1, 1, 0, 6'h00, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("b2b_wr2", 1, 0, 16'h000F, 6'h06, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("b2b_gap2", 1, 1, 0, 6'h00, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("b2b_wr3", 1, 0, 16'h00FF, 6'h06, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("b2b_stop1", 75, 1, 0, 6'h07, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("b2b_ld2", 1, 1, 0, 6'h07, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      vt.push_back(mk($sformatf("b2b_bit%0d", k), CPB, 1, 0, 6'h05, f0[k], 0, 0, 0, 0, 0));
    vt.push_back(mk("b2b_stop2", CPB, 1, 0, 6'h05, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("b2b_done", CPB, 1, 0, 6'h07, 1, 1, 1, 0, 0, 0));
    vt.push_back(mk("b2b_idle", 20, 1, 0, 6'h07, 1, 1, 1, 0, 0, 0));

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    foreach (vt[i]) begin
      wrn = vt[i].wrn;
      data_i = vt[i].din;
      repeat (vt[i].cyc) step();
      if (vt[i].m[0]) chk({vt[i].nm, ".txd"},  {15'd0, txd},        {15'd0, vt[i].txd});
      if (vt[i].m[1]) chk({vt[i].nm, ".tbre"}, {15'd0, tbre},       {15'd0, vt[i].tbre});
      if (vt[i].m[2]) chk({vt[i].nm, ".tsre"}, {15'd0, tsre},       {15'd0, vt[i].tsre});
      if (vt[i].m[3]) chk({vt[i].nm, ".dr"},   {15'd0, data_ready}, {15'd0, vt[i].dr});
      if (vt[i].m[4]) chk({vt[i].nm, ".ov"},   {15'd0, overrun},    {15'd0, vt[i].ov});
      if (vt[i].m[5]) chk({vt[i].nm, ".dout"}, data_o, vt[i].dout);
    end
    wrn = 1'b1;

    // Single receive and read.
    send_byte(8'h3C, 1'b1);
    chk("rx3c.dr", {15'd0, data_ready}, 16'd1);
    chk("rx3c.ov", {15'd0, overrun}, 16'd0);
    do_read("rx3c", 16'h003C);

    // Two bytes without reading: overrun.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("ovr.dr", {15'd0, data_ready}, 16'd1);
    chk("ovr.ov", {15'd0, overrun}, 16'd1);

    // Byte completes on the same cycle as the read-end: stays ready, overrun cleared.
    fork
      send_byte(8'h99, 1'b1);
      begin
        rdn = 1'b0;
        step();
        chk("coinc.old_rbr", data_o, 16'h0022);
        repeat (77) step();
        rdn = 1'b1;
        step();
      end
    join
    chk("coinc.dr", {15'd0, data_ready}, 16'd1);
    chk("coinc.ov", {15'd0, overrun}, 16'd0);
    do_read("coinc", 16'h0099);

    // Overrun again, then an ordinary read clears both flags.
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    chk("ovr2.ov", {15'd0, overrun}, 16'd1);
    do_read("ovr2", 16'h0044);

    // Short low glitch is not a start bit.
    rxd = 1'b0;
    repeat (3) step();
    rxd = 1'b1;
    repeat (40) step();
    chk("glitch.dr", {15'd0, data_ready}, 16'd0);

    // Framing error: byte discarded, rbr unchanged.
    send_byte(8'h77, 1'b0);
    repeat (20) step();
    chk("frame.dr", {15'd0, data_ready}, 16'd0);
    do_read("frame", 16'h0044);

    // Reset with both directions mid-frame and flags set.
    send_byte(8'h5A, 1'b1);
    send_byte(8'h6B, 1'b1);
    wrn = 1'b0; data_i = 16'h00A5;
    step();
    wrn = 1'b1;
    repeat (20) step();
    chk("rst.tx_busy", {15'd0, tsre}, 16'd0);
    rxd = 1'b0;
    repeat (30) step();
    rdn = 1'b0;
    step();
    chk("rst.pre_dout", data_o, 16'h006B);
    rst = 1'b1; rxd = 1'b1; rdn = 1'b1;
    step();
    chk("rst.txd",  {15'd0, txd}, 16'd1);
    chk("rst.tbre", {15'd0, tbre}, 16'd1);
    chk("rst.tsre", {15'd0, tsre}, 16'd1);
    chk("rst.dr",   {15'd0, data_ready}, 16'd0);
    chk("rst.ov",   {15'd0, overrun}, 16'd0);
    chk("rst.dout", data_o, 16'h0000);
    rst = 1'b0;
    repeat (5) step();
    send_byte(8'hC3, 1'b1);
    chk("post.dr", {15'd0, data_ready}, 16'd1);
    chk("post.ov", {15'd0, overrun}, 16'd0);
    chk("post.txd", {15'd0, txd}, 16'd1);
    do_read("post", 16'h00C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
